// File: rtl/avalon_pio_out_blink_if.sv
// Avalon-MM slave bus bundle for the blinking output PIO.
// Zero-wait-state: readdata is combinational from address.
interface avalon_pio_out_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_pio_out_blink.sv
// Avalon-MM output PIO with atomic SET/CLEAR/TOGGLE ports and a per-bit
// hardware blink driven by a programmable prescaler.
module avalon_pio_out_blink #(
    parameter int WIDTH       = 10,
    parameter int RESET_VALUE = 597,
    parameter int DIV_W       = 24,
    parameter int DIV_RESET   = 2499999
) (
    input  logic                   clk,
    input  logic                   reset_n,
    avalon_pio_out_blink_if.slave  bus,
    output logic [WIDTH-1:0]       out_port
);

    localparam logic [WIDTH-1:0] DATA_RST = WIDTH'(RESET_VALUE);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_RESET);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd1;
    localparam logic [2:0] A_CLEAR  = 3'd2;
    localparam logic [2:0] A_TOGGLE = 3'd3;
    localparam logic [2:0] A_BLINK  = 3'd4;
    localparam logic [2:0] A_DIV    = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink_en;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [DIV_W-1:0] w_wd_div;
    logic [31:0]      w_rdata;

    assign w_wr     = bus.chipselect && !bus.write_n;
    assign w_wd     = bus.writedata[WIDTH-1:0];
    assign w_wd_div = bus.writedata[DIV_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= DATA_RST;
            r_blink_en <= '0;
        end else if (w_wr) begin
            case (bus.address)
                A_DATA:   r_data     <= w_wd;
                A_SET:    r_data     <= r_data | w_wd;
                A_CLEAR:  r_data     <= r_data & ~w_wd;
                A_TOGGLE: r_data     <= r_data ^ w_wd;
                A_BLINK:  r_blink_en <= w_wd;
                default:  ;
            endcase
        end
    end

    // A BLINK_DIV write outranks the terminal count: cnt clears, phase holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= DIV_RST;
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_wr && bus.address == A_DIV) begin
            r_div <= w_wd_div;
            r_cnt <= '0;
        end else if (r_cnt == r_div) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            A_DATA:   w_rdata[WIDTH-1:0] = r_data;
            A_BLINK:  w_rdata[WIDTH-1:0] = r_blink_en;
            A_DIV:    w_rdata[DIV_W-1:0] = r_div;
            A_STATUS: w_rdata[0]         = r_phase;
            default:  ;
        endcase
    end

    assign bus.readdata = w_rdata;

    // Register-only path to the pins; blinking bits gate data with phase.
    assign out_port = r_data & (~r_blink_en | {WIDTH{r_phase}});

endmodule
